hazard_ctrl: RTL

Pipeline hazard controller. It generates the PC enable, the IF/ID write enable (FI_ID_RegWr), the IF/ID flush and the ID/EX bubble that the stage registers consume. It handles three cases: load-use stalls, taken-branch/jump redirects resolved in ID, and a multi-cycle multiply/divide unit (MDU) interlock. It sits beside the decode stage and drives every stall/flush input of the IF and ID stage registers.

---
 rtl/hazard_if.sv | 34 +++
 rtl/hazard_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// Decode/execute-side signals of the pipeline hazard controller.
// master = pipeline (decode/EX field drivers), slave = hazard_ctrl.
interface hazard_if;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic        uses_rt_d;
  logic        mdu_start_d;
  logic        hilo_rd_d;
  logic        pcsrc_d;
  logic        regwrite_e;
  logic        memtoreg_e;
  logic [4:0]  writereg_e;
  logic        pc_en;
  logic        fi_id_regwr;
  logic        flush_ifid;
  logic        flush_idex;
  logic        mdu_busy;
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;

  modport master (
    output rs_d, rt_d, uses_rt_d, mdu_start_d, hilo_rd_d, pcsrc_d,
           regwrite_e, memtoreg_e, writereg_e,
    input  pc_en, fi_id_regwr, flush_ifid, flush_idex, mdu_busy,
           stall_cycles, flush_cycles
  );

  modport slave (
    input  rs_d, rt_d, uses_rt_d, mdu_start_d, hilo_rd_d, pcsrc_d,
           regwrite_e, memtoreg_e, writereg_e,
    output pc_en, fi_id_regwr, flush_ifid, flush_idex, mdu_busy,
           stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, ID-resolved branch flush, MDU interlock.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             lu, md, stall, busy;

  assign busy  = (state == MDU_WAIT);

  // $0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign lu = hz.memtoreg_e & hz.regwrite_e & (hz.writereg_e != 5'd0) &
              ((hz.writereg_e == hz.rs_d) |
               (hz.uses_rt_d & (hz.writereg_e == hz.rt_d)));
  assign md    = busy & (hz.hilo_rd_d | hz.mdu_start_d);
  assign stall = lu | md;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (hz.mdu_start_d && !stall) begin
          state_next = MDU_WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      MDU_WAIT: begin
        if (cnt == '0) state_next = RUN;
        else           cnt_next   = cnt - 1'b1;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Stall holds a taken branch in ID, so its IF/ID flush waits until the stall clears.
  always_comb begin
    hz.pc_en       = 1'b1;
    hz.fi_id_regwr = 1'b1;
    hz.flush_ifid  = hz.pcsrc_d;
    hz.flush_idex  = 1'b0;
    hz.mdu_busy    = busy;
    if (!rst_n) begin
      hz.pc_en       = 1'b0;
      hz.fi_id_regwr = 1'b0;
      hz.flush_ifid  = 1'b1;
      hz.flush_idex  = 1'b1;
      hz.mdu_busy    = 1'b0;
    end else if (stall) begin
      hz.pc_en       = 1'b0;
      hz.fi_id_regwr = 1'b0;
      hz.flush_ifid  = 1'b0;
      hz.flush_idex  = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 32'hFFFF_FFFF)         stall_cnt <= stall_cnt + 32'd1;
      if (hz.flush_ifid && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_cycles = flush_cnt;
`else
  assign hz.stall_cycles = 32'd0;
  assign hz.flush_cycles = 32'd0;
`endif

endmodule
